// File: rtl/nem_ohmux_sel_ctrl.sv
// nem_ohmux_sel_ctrl: drives the one-hot select lines of the NEM inverting mux.
// Binary requests become one-hot selects. When the selection changes, all lines
// are held low for a dead time, and the mux is flagged settled only after the
// relay settle interval. Out-of-range requests set a sticky error flag.
module nem_ohmux_sel_ctrl #(
    parameter int N_SEL      = 2,
    parameter int SEL_W      = 1,
    parameter int BREAK_CYC  = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             REQ_VALID,
    input  logic [SEL_W-1:0] REQ_SEL,
    output logic             REQ_READY,
    output logic [N_SEL-1:0] S,
    output logic             SETTLED,
    output logic [SEL_W-1:0] CUR_SEL,
    output logic             ERR
);

    localparam int MAX_CYC = (BREAK_CYC > SETTLE_CYC) ? BREAK_CYC : SETTLE_CYC;
    localparam int CNT_W   = (MAX_CYC <= 2) ? 1 : $clog2(MAX_CYC);

    localparam logic [CNT_W-1:0] BREAK_LOAD  = CNT_W'(BREAK_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] MAX_IDX     = SEL_W'(N_SEL - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAKE,
        ST_HOLD
    } state_e;

    state_e             state_q,   state_d;
    logic [CNT_W-1:0]   cnt_q,     cnt_d;
    logic [N_SEL-1:0]   s_q,       s_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic               settled_q, settled_d;
    logic               ready_q,   ready_d;
    logic               err_q,     err_d;

    logic               accept;
    logic               in_range;

    assign accept   = REQ_VALID && ready_q;
    assign in_range = (REQ_SEL <= MAX_IDX);

    function automatic logic [N_SEL-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [N_SEL-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < N_SEL; i++) begin
            v[i] = (SEL_W'(i) == idx);
        end
        return v;
    endfunction

    // Next-state and next-output computation for the break-before-make sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        s_d       = s_q;
        cur_sel_d = cur_sel_q;
        settled_d = settled_q;
        ready_d   = ready_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else begin
                        // Nothing is made yet, so no dead time is needed.
                        state_d   = ST_MAKE;
                        s_d       = onehot(REQ_SEL);
                        cur_sel_d = REQ_SEL;
                        cnt_d     = SETTLE_LOAD;
                        ready_d   = 1'b0;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    if (!in_range) begin
                        err_d = 1'b1;
                    end else if (REQ_SEL != cur_sel_q) begin
                        state_d   = ST_BREAK;
                        s_d       = '0;
                        settled_d = 1'b0;
                        cur_sel_d = REQ_SEL;
                        cnt_d     = BREAK_LOAD;
                        ready_d   = 1'b0;
                    end
                end
            end
            ST_BREAK: begin
                if (cnt_q == '0) begin
                    state_d = ST_MAKE;
                    s_d     = onehot(cur_sel_q);
                    cnt_d   = SETTLE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_MAKE: begin
                if (cnt_q == '0) begin
                    state_d   = ST_HOLD;
                    settled_d = 1'b1;
                    ready_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops all selects.
    always_ff @(posedge CP) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            s_q       <= '0;
            cur_sel_q <= '0;
            settled_q <= 1'b0;
            ready_q   <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_q       <= s_d;
            cur_sel_q <= cur_sel_d;
            settled_q <= settled_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
        end
    end

    assign REQ_READY = ready_q;
    assign S         = s_q;
    assign SETTLED   = settled_q;
    assign CUR_SEL   = cur_sel_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_nem_ohmux_sel_ctrl.sv
// Bench for nem_ohmux_sel_ctrl with three inputs, so out-of-range requests
// are reachable. The reference model tracks the edge at which the selects
// turn on and the edge at which the mux settles, rather than states.
module tb_nem_ohmux_sel_ctrl;

    localparam int N_SEL      = 3;
    localparam int SEL_W      = 2;
    localparam int BREAK_CYC  = 2;
    localparam int SETTLE_CYC = 4;

    logic             cp;
    logic             rst;
    logic             req_valid;
    logic [SEL_W-1:0] req_sel;
    logic             req_ready;
    logic [N_SEL-1:0] s;
    logic             settled;
    logic [SEL_W-1:0] cur_sel;
    logic             err;

    nem_ohmux_sel_ctrl #(
        .N_SEL     (N_SEL),
        .SEL_W     (SEL_W),
        .BREAK_CYC (BREAK_CYC),
        .SETTLE_CYC(SETTLE_CYC)
    ) dut (
        .CP       (cp),
        .RST      (rst),
        .REQ_VALID(req_valid),
        .REQ_SEL  (req_sel),
        .REQ_READY(req_ready),
        .S        (s),
        .SETTLED  (settled),
        .CUR_SEL  (cur_sel),
        .ERR      (err)
    );

    initial cp = 1'b0;
    always #5 cp = ~cp;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Reference model: edge count plus timestamps of the current selection.
    int m_edge      = 0;
    int m_active    = 0;
    int m_cur       = 0;
    int m_err       = 0;
    int m_s_on_at   = 0;
    int m_settle_at = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s:%s got=%0h exp=%0h (edge %0d)", phase, tag, got, exp, m_edge);
        end
    endtask

    // One clock edge: update the model from the sampled inputs, then compare.
    task automatic step();
        int ready_before;
        int n;
        int exp_s;
        ready_before = (m_active == 0 || m_edge >= m_settle_at) ? 1 : 0;
        n = int'(req_sel);
        @(posedge cp);
        m_edge++;
        if (rst) begin
            m_active = 0;
            m_cur    = 0;
            m_err    = 0;
        end else if (req_valid && ready_before != 0) begin
            if (n >= N_SEL) begin
                m_err = 1;
            end else if (m_active == 0) begin
                m_active    = 1;
                m_cur       = n;
                m_s_on_at   = m_edge;
                m_settle_at = m_edge + SETTLE_CYC;
            end else if (n != m_cur) begin
                m_cur       = n;
                m_s_on_at   = m_edge + BREAK_CYC;
                m_settle_at = m_edge + BREAK_CYC + SETTLE_CYC;
            end
        end
        #1;
        exp_s = (m_active != 0 && m_edge >= m_s_on_at) ? (1 << m_cur) : 0;
        chk("S",       32'(s),         32'(exp_s));
        chk("SETTLED", 32'(settled),   32'((m_active != 0 && m_edge >= m_settle_at) ? 1 : 0));
        chk("READY",   32'(req_ready), 32'((m_active == 0 || m_edge >= m_settle_at) ? 1 : 0));
        chk("CUR_SEL", 32'(cur_sel),   32'(m_cur));
        chk("ERR",     32'(err),       32'(m_err));
        chk("ONEHOT",  32'(($countones(s) <= 1) ? 1 : 0), 32'(1));
    endtask

    task automatic drive(input logic r, input logic v, input int sel);
        rst       = r;
        req_valid = v;
        req_sel   = SEL_W'(sel);
    endtask

    task automatic idle_steps(input int count);
        drive(1'b0, 1'b0, 0);
        for (int i = 0; i < count; i++) step();
    endtask

    initial begin
        drive(1'b1, 1'b0, 0);

        phase = "reset";
        step();
        step();

        phase = "idle_to_1";
        drive(1'b0, 1'b1, 1);
        step();
        idle_steps(5);

        phase = "hold1_to_0";
        drive(1'b0, 1'b1, 0);
        step();
        idle_steps(7);

        phase = "hold0_same";
        drive(1'b0, 1'b1, 0);
        step();
        step();
        idle_steps(1);

        phase = "out_of_range";
        drive(1'b0, 1'b1, 2);
        step();
        idle_steps(8);
        drive(1'b0, 1'b1, 3);
        step();
        idle_steps(2);
        drive(1'b0, 1'b1, 1);
        step();
        idle_steps(8);
        drive(1'b1, 1'b0, 0);
        step();

        phase = "rst_mid_make";
        drive(1'b0, 1'b1, 2);
        step();
        idle_steps(2);
        drive(1'b1, 1'b0, 0);
        step();
        drive(1'b0, 1'b1, 1);
        step();
        idle_steps(6);

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            req_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) req_sel = SEL_W'($urandom_range(0, 3));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/nem_ohmux_sel_ctrl.md
NEM_OHMUX_SEL_CTRL -- requirements
Module: nem_ohmux_sel_ctrl

Purpose: upstream controller for the NEM one-hot inverting mux. Converts a binary select request into one-hot relay select lines, with break-before-make dead time and a relay settle interval.

Interface
REQ-001 Parameter N_SEL, default 2: number of mux inputs and select lines; legal range 2..8.
REQ-002 Parameter SEL_W, default 1: request index width; SEL_W SHALL equal clog2(N_SEL).
REQ-003 Parameter BREAK_CYC, default 2: all-selects-low dead time in cycles; minimum 1.
REQ-004 Parameter SETTLE_CYC, default 4: relay settle time in cycles after make; minimum 1.
REQ-005 CP  input  1  clock; all state updates on the rising edge.
REQ-006 RST  input  1  reset; synchronous, active-high.
REQ-007 REQ_VALID  input  1  select request valid.
REQ-008 REQ_SEL  input  SEL_W  requested input index.
REQ-009 REQ_READY  output  1  controller can accept a request.
REQ-010 S  output  N_SEL  one-hot select lines; S[i] drives mux select Si.
REQ-011 SETTLED  output  1  mux output is valid for CUR_SEL.
REQ-012 CUR_SEL  output  SEL_W  index currently made or being made.
REQ-013 ERR  output  1  sticky flag: an out-of-range request was seen.

Function
REQ-014 The FSM SHALL have four states: IDLE, BREAK, MAKE, HOLD. All outputs SHALL be registered.
REQ-015 REQ_READY SHALL be 1 in IDLE and HOLD, and 0 in BREAK and MAKE.
REQ-016 A request SHALL be accepted on a rising edge where REQ_VALID=1 and REQ_READY=1.
REQ-017 IDLE, accept in-range index n: next state MAKE; S=onehot(n); CUR_SEL=n; settle counter loaded with SETTLE_CYC-1.
REQ-018 HOLD, accept in-range n different from CUR_SEL:
- next state BREAK; S=0; SETTLED=0; break counter loaded with BREAK_CYC-1;
- CUR_SEL=n from the same edge.
REQ-019 HOLD, accept n equal to CUR_SEL: no state or output change; SETTLED stays 1.
REQ-020 BREAK: counter decrements each cycle; at 0, next state MAKE, S=onehot(CUR_SEL), settle counter loaded with SETTLE_CYC-1.
REQ-021 MAKE: counter decrements each cycle; at 0, next state HOLD with SETTLED=1.
REQ-022 Timing from HOLD: S=0 for exactly BREAK_CYC cycles, then SETTLED rises SETTLE_CYC cycles after S goes nonzero.
REQ-023 At most one bit of S SHALL be 1 in every cycle. Two consecutive nonzero S values SHALL never differ.
REQ-024 Accept with REQ_SEL >= N_SEL:
- ERR=1 from the next cycle;
- state, S, CUR_SEL and SETTLED unchanged.
REQ-025 ERR SHALL clear only on RST.
REQ-026 Counters SHALL be wide enough for max(BREAK_CYC, SETTLE_CYC)-1 and SHALL never wrap.
REQ-027 REQ_VALID while REQ_READY=0 SHALL be ignored. Requests are not queued; the requester holds REQ_VALID.

Reset
REQ-028 While RST=1 at an edge, outputs SHALL be: state IDLE, S=0, SETTLED=0, CUR_SEL=0, ERR=0, REQ_READY=1, counters 0.
REQ-029 RST in any state, including mid-BREAK or mid-MAKE, SHALL force S=0 from the following cycle.
REQ-030 After RST deasserts, a request MAY be accepted on the first edge.

Verification (defaults N_SEL=2, BREAK_CYC=2, SETTLE_CYC=4 unless stated)
REQ-031 RST=1 for 2 cycles -> S=00, SETTLED=0, REQ_READY=1, CUR_SEL=0, ERR=0.
REQ-032 From IDLE, REQ_SEL=1 accepted at edge k:
- S=10 and REQ_READY=0 after edge k;
- SETTLED=1 and REQ_READY=1 after edge k+4.
REQ-033 From HOLD on sel 1, REQ_SEL=0 accepted at edge k:
- S=00 after edges k and k+1;
- S=01 after edge k+2;
- SETTLED=1 after edge k+6;
- S=11 never observed.
REQ-034 HOLD on sel 0, REQ_SEL=0 accepted -> S=01 and SETTLED=1 unchanged; REQ_READY stays 1.
REQ-035 N_SEL=3, SEL_W=2, HOLD on sel 2, REQ_SEL=3 accepted:
- ERR=1 next cycle; S=100 unchanged;
- ERR still 1 after later valid requests; ERR=0 after RST.
REQ-036 RST asserted 2 cycles into MAKE -> S=0, SETTLED=0 next cycle; a new request for sel 1 then completes with normal timing.
